// File: rtl/alu_issue.sv
// Issue/writeback controller for the bit-serial ALU: decodes RV32I OP/OP-IMM into an ALU op,
// runs the start/done handshake with operands held in registers, and drives the register-file write port.
module alu_issue #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_func3,
    input  logic [6:0]        in_func7,
    input  logic [11:0]       in_imm,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [4:0]        in_rd_addr,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [3:0]        alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal
);

    localparam int         CNT_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_START,
        S_WAIT,
        S_WB
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   drain_cnt;
    logic [4:0]         rd_q;

    logic               dec_legal;
    logic [3:0]         dec_op;
    logic [DATA_W-1:0]  dec_b;

    // Decode of the instruction presented on the input port.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = {1'b0, in_func3};
        dec_b     = in_rs2_data;
        case (in_opcode)
            OPC_OP: begin
                dec_op    = {in_func7[5], in_func3};
                dec_legal = (in_func7 == 7'd0) ||
                            ((in_func7 == F7_ALT) && ((in_func3 == 3'b000) || (in_func3 == 3'b101)));
            end
            OPC_IMM: begin
                // Only SRAI uses imm[10] as the alternate bit; ADDI never becomes SUB.
                dec_op = {(in_func3 == 3'b101) & in_imm[10], in_func3};
                dec_b  = {{(DATA_W-12){in_imm[11]}}, in_imm};
                case (in_func3)
                    3'b001:  dec_legal = (in_imm[11:5] == 7'd0);
                    3'b101:  dec_legal = (in_imm[11:5] == 7'd0) || (in_imm[11:5] == F7_ALT);
                    default: dec_legal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
            rd_q      <= '0;
            in_ready  <= 1'b0;
            alu_start <= 1'b0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
            alu_op    <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            illegal   <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                // The ALU is not reset; give any in-flight operation time to finish.
                S_DRAIN: begin
                    if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        alu_rs1 <= in_rs1_data;
                        alu_rs2 <= dec_b;
                        alu_op  <= dec_op;
                        rd_q    <= in_rd_addr;
                        if (dec_legal) begin
                            state     <= S_START;
                            alu_start <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    alu_start <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        wb_data <= alu_rd;
                        if (rd_q == 5'd0) begin
                            state    <= S_IDLE;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= S_WB;
                            wb_valid <= 1'b1;
                            wb_addr  <= rd_q;
                        end
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_DRAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: an ALU stub answers start requests, and an instruction-level
// reference model predicts legality, op code, operand B and the written-back result.
module tb_alu_issue;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode, in_func7;
    logic [2:0]  in_func3;
    logic [11:0] in_imm;
    logic [31:0] in_rs1_data, in_rs2_data;
    logic [4:0]  in_rd_addr;
    logic [31:0] alu_rs1, alu_rs2, alu_rd, wb_data;
    logic [3:0]  alu_op;
    logic        alu_start, alu_done, wb_valid, wb_ready, illegal;
    logic [4:0]  wb_addr;

    int n_checks = 0;
    int n_errors = 0;
    int stub_lat = 1;

    alu_issue #(.DATA_W(32), .DRAIN_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rd_addr(in_rd_addr),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_rd(alu_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction-level reference: RV32I semantics from the instruction fields.
    function automatic logic ref_legal(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7, logic [11:0] imm);
        if (opc == OP) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (opc == OPIMM) begin
            if (f3 == 3'd1) return imm[11:5] == 7'h00;
            if (f3 == 3'd5) return (imm[11:5] == 7'h00) || (imm[11:5] == 7'h20);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_opb(logic [6:0] opc, logic [11:0] imm, logic [31:0] rs2);
        return (opc == OP) ? rs2 : {{20{imm[11]}}, imm};
    endfunction

    function automatic logic [3:0] ref_op(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7, logic [11:0] imm);
        return (opc == OP) ? {f7[5], f3} : {(f3 == 3'd5) & imm[10], f3};
    endfunction

    function automatic logic [31:0] ref_result(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                                               logic [11:0] imm, logic [31:0] a, logic [31:0] rs2);
        logic [31:0] b;
        logic        alt;
        b   = ref_opb(opc, imm, rs2);
        alt = (opc == OP) ? f7[5] : imm[10];
        case (f3)
            3'd0: return (opc == OP && alt) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Behaviour of the ALU as seen through its op code.
    function automatic logic [31:0] stub_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op[2:0])
            3'd0: return op[3] ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return op[3] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    logic [3:0]  s_op;
    logic [31:0] s_a, s_b;
    logic        s_abort;

    // ALU stub: samples start, answers with a done pulse stub_lat cycles later unless reset intervenes.
    initial begin
        alu_done = 1'b0;
        alu_rd   = '0;
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1 && rst === 1'b1) begin
                s_op = alu_op; s_a = alu_rs1; s_b = alu_rs2; s_abort = 1'b0;
                @(posedge clk);
                for (int k = 1; k < stub_lat && !s_abort; k++) begin
                    @(posedge clk);
                    if (!rst) s_abort = 1'b1;
                end
                if (!rst) s_abort = 1'b1;
                if (!s_abort) begin
                    #1;
                    chk("hold_op", {28'd0, alu_op}, {28'd0, s_op});
                    chk("hold_rs1", alu_rs1, s_a);
                    chk("hold_rs2", alu_rs2, s_b);
                    alu_rd   = stub_alu(s_op, s_a, s_b);
                    alu_done = 1'b1;
                    @(posedge clk);
                    #1 alu_done = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [11:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd);
        in_opcode = opc; in_func3 = f3; in_func7 = f7; in_imm = imm;
        in_rs1_data = rs1; in_rs2_data = rs2; in_rd_addr = rd;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [11:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [4:0] rd, input int lat, input int stall, input logic poke);
        logic [31:0] exp_res, held;
        int n;
        exp_res = ref_result(opc, f3, f7, imm, rs1, rs2);
        wait_ready();
        stub_lat = lat;
        drive(opc, f3, f7, imm, rs1, rs2, rd);
        if (!ref_legal(opc, f3, f7, imm)) begin
            chk("illegal_pulse", {31'd0, illegal}, 32'd1);
            chk("illegal_nostart", {31'd0, alu_start}, 32'd0);
            chk("illegal_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            chk("illegal_clear", {31'd0, illegal}, 32'd0);
            chk("illegal_nostart2", {31'd0, alu_start}, 32'd0);
            chk("illegal_nowb", {31'd0, wb_valid}, 32'd0);
            return;
        end
        chk("start_pulse", {31'd0, alu_start}, 32'd1);
        chk("alu_op", {28'd0, alu_op}, {28'd0, ref_op(opc, f3, f7, imm)});
        chk("alu_rs1", alu_rs1, rs1);
        chk("alu_rs2", alu_rs2, ref_opb(opc, imm, rs2));
        chk("busy_start", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("start_drop", {31'd0, alu_start}, 32'd0);
        n = 0;
        while (alu_done !== 1'b1 && n < lat + 8) begin
            if (poke) begin
                in_valid = 1'b1;
                in_rs1_data = $urandom;
            end
            @(negedge clk);
            n++;
            if (alu_start !== 1'b0) chk("start_single", {31'd0, alu_start}, 32'd0);
            if (poke) chk("busy_wait", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("done_seen", {31'd0, alu_done}, 32'd1);
        if (alu_done !== 1'b1) return;
        @(negedge clk);
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, rd != 5'd0});
        if (poke) chk("rs1_held", alu_rs1, rs1);
        if (rd == 5'd0) begin
            chk("rd0_ready", {31'd0, in_ready}, 32'd1);
            return;
        end
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
        chk("wb_data", wb_data, exp_res);
        chk("busy_wb", {31'd0, in_ready}, 32'd0);
        held = wb_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, wb_valid}, 32'd1);
            chk("stall_data", wb_data, held);
            chk("stall_addr", {27'd0, wb_addr}, {27'd0, rd});
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk("wb_release", {31'd0, wb_valid}, 32'd0);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_start"}, {31'd0, alu_start}, 32'd0);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
        chk({tag, "_alu_rs1"}, alu_rs1, 32'd0);
        chk({tag, "_alu_rs2"}, alu_rs2, 32'd0);
        chk({tag, "_wb_addr"}, {27'd0, wb_addr}, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  r_opc, r_f7;
        logic [11:0] r_imm;
        int          r;
        rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
        in_opcode = '0; in_func3 = '0; in_func7 = '0; in_imm = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_rd_addr = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed cases
        run_instr(OP, 3'd0, 7'h00, 12'h000, 32'd5, 32'd7, 5'd3, 32, 0, 1'b0);
        run_instr(OPIMM, 3'd0, 7'h00, 12'hFFF, 32'd100, 32'd0, 5'd1, 4, 0, 1'b0);
        run_instr(OPIMM, 3'd5, 7'h00, 12'h403, 32'h8000_0010, 32'd0, 5'd2, 5, 0, 1'b0);
        run_instr(OP, 3'd4, 7'h20, 12'h000, 32'd1, 32'd2, 5'd4, 3, 0, 1'b0);
        run_instr(OPIMM, 3'd1, 7'h00, 12'h420, 32'd1, 32'd0, 5'd4, 3, 0, 1'b0);
        run_instr(OP, 3'd2, 7'h00, 12'h000, 32'hFFFF_FFFE, 32'd3, 5'd9, 63, 5, 1'b0);
        run_instr(OP, 3'd0, 7'h20, 12'h000, 32'd50, 32'd8, 5'd0, 6, 0, 1'b0);
        run_instr(OP, 3'd7, 7'h00, 12'h000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd12, 10, 2, 1'b1);

        // Randomized instruction mix
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            r_opc = (r < 5) ? OP : (r < 9) ? OPIMM : 7'($urandom);
            r = $urandom_range(0, 3);
            r_f7 = (r < 2) ? 7'h00 : (r == 2) ? 7'h20 : 7'($urandom);
            r = $urandom_range(0, 3);
            r_imm = (r == 0) ? {7'h00, 5'($urandom)} : (r == 1) ? {7'h20, 5'($urandom)} : 12'($urandom);
            run_instr(r_opc, 3'($urandom), r_f7, r_imm, $urandom, $urandom,
                      ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                      $urandom_range(1, 20), $urandom_range(0, 3), 1'($urandom));
        end

        // Reset in the middle of WAIT
        wait_ready();
        stub_lat = 40;
        drive(OP, 3'd0, 7'h20, 12'h000, 32'hA5A5_5A5A, 32'h1234_5678, 5'd5);
        chk("rst_pre_start", {31'd0, alu_start}, 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 10) begin
                alu_rd   = 32'hDEAD_BEEF;
                alu_done = 1'b1;
                in_valid = 1'b1;
            end
            if (k == 11) begin
                alu_done = 1'b0;
                in_valid = 1'b0;
            end
            chk("drain_ready", {31'd0, in_ready}, (k < 64) ? 32'd0 : 32'd1);
            chk("drain_nowb", {31'd0, wb_valid}, 32'd0);
            chk("drain_nostart", {31'd0, alu_start}, 32'd0);
        end
        run_instr(OP, 3'd1, 7'h00, 12'h000, 32'd3, 32'd4, 5'd7, 8, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue and writeback controller directly upstream of the bit-serial `alu`. It accepts one decoded RV32I R-type or OP-IMM instruction with its register operands and maps `func3`/`func7` to the ALU's 4-bit op code. It drives the ALU's `start`/`done` handshake, holding operands stable while the ALU runs, and presents the result to the register-file write port. It serialises one instruction at a time.

## Interface
- `DRAIN_CYCLES`, 64: number of cycles after reset release during which `in_ready` stays 0, letting an un-reset ALU finish any in-flight operation (longest ALU op is 63 cycles).
- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: upstream instruction valid.
- `in_ready` output 1: block can accept; a transfer happens when `in_valid & in_ready` at posedge.
- `in_opcode` input 7: 7'b0110011 (OP) or 7'b0010011 (OP-IMM).
- `in_func3` input 3: instruction func3.
- `in_func7` input 7: instruction func7; OP only.
- `in_imm` input 12: I-immediate; OP-IMM only.
- `in_rs1_data` input 32: rs1 register value.
- `in_rs2_data` input 32: rs2 register value; OP only.
- `in_rd_addr` input 5: destination register.
- `alu_rs1` output 32: ALU operand A.
- `alu_rs2` output 32: ALU operand B, either rs2 or the sign-extended immediate.
- `alu_op` output 4: ALU op code.
- `alu_start` output 1: ALU start request.
- `alu_done` input 1: ALU one-cycle completion pulse.
- `alu_rd` input 32: ALU result.
- `wb_valid` output 1: writeback request.
- `wb_ready` input 1: register file accepts the write.
- `wb_addr` output 5: write address.
- `wb_data` output 32: write data.
- `illegal` output 1: one-cycle pulse for an unsupported encoding.

## Operation
- States: DRAIN, IDLE, START, WAIT, WB. Reset state is DRAIN, with the drain counter at 0.
- **DRAIN**
  - Counter increments each cycle.
  - Goes to IDLE when the counter reaches `DRAIN_CYCLES-1`.
  - `alu_done` is ignored.
- **IDLE**
  - `in_ready`=1.
  - On transfer, latch operands, op and `rd`.
  - Legal encoding: go to START.
  - Illegal encoding: pulse `illegal` next cycle and stay in IDLE. No ALU start, no writeback.
- **START**
  - `alu_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - `alu_start`=0.
  - On `alu_done`=1, capture `alu_rd` into `wb_data`.
  - If `rd`==0, go to IDLE with no writeback; otherwise go to WB.
- **WB**
  - `wb_valid`=1 until `wb_ready`=1 at posedge, then go to IDLE.
  - `wb_addr` and `wb_data` are held stable while `wb_valid`=1.
- **Op mapping**
  - OP: `alu_op`={`func7[5]`, `func3`}.
    - Legal `func7` values: 7'b0000000 with any `func3`, or 7'b0100000 with `func3` 000 or 101.
  - OP-IMM: `alu_op`={(`func3`==101) & `imm[10]`, `func3`}.
    - `func3`=001: legal only if `imm[11:5]`==0.
    - `func3`=101: legal only if `imm[11:5]` is 0000000 or 0100000.
    - ADDI never maps to SUB, whatever `imm[10]` is.
  - Any other opcode is illegal.
- **Operand B**: OP uses `in_rs2_data`. OP-IMM uses {{20{`imm[11]`}}, `imm`}; for shifts only bits [4:0] matter to the ALU.
- **Operand hold**: `alu_rs1`, `alu_rs2` and `alu_op` are driven from registers. They are stable from entry to START until the cycle after `alu_done`, because the ALU reads operands combinationally throughout compute.
- `alu_done` outside WAIT is ignored.

## Timing
- **Reset values**:
  - `in_ready`=0, `alu_start`=0, `wb_valid`=0, `illegal`=0.
  - `alu_op`=0, `alu_rs1`=0, `alu_rs2`=0, `wb_addr`=0, `wb_data`=0.
- **Start sampling**: accept at edge T0 → START during T0..T1 → ALU samples start at T1.
  - `alu_op` is already valid before T1, because the ALU sets carry and sign controls from `op` while idle.
- **Latency**: ALU `done` arrives N cycles later (ADD N=32, SLT N=63). `wb_valid` rises the cycle after `done` is seen.
  - Accept-to-`wb_valid` = N+2 cycles.
- **Throughput**: `in_ready` is 0 from START until return to IDLE, so there is no overlap.
- **Asynchronous reset mid-operation**:
  - All outputs return to reset values immediately and the FSM enters DRAIN.
  - Any pending writeback is dropped.
  - An ALU `done` arriving during DRAIN is discarded.

## Test plan
- **ADD**: OP ADD, rs1=5, rs2=7, rd=3 → `alu_op`=0000, single `alu_start` pulse; after stub `done` with `alu_rd`=12 → `wb_valid`, `wb_addr`=3, `wb_data`=12.
- **ADDI / SRAI mapping**: ADDI `imm`=12'hFFF → `alu_rs2`=32'hFFFFFFFF, `alu_op`=0000. SRAI `imm`=12'h403 → `alu_op`=1101, `alu_rs2[4:0]`=3.
- **Illegal encodings**: OP `func7`=7'b0100000 with `func3`=100, then SLLI `imm`=12'h420 → `illegal` pulse each, no `alu_start`, `in_ready` back to 1 next cycle.
- **Backpressure and rd=0**:
  - `wb_ready` held 0 for 5 cycles → `wb_valid`/`wb_data` stable, `in_ready`=0, single write on release.
  - rd=0 → no `wb_valid`.
- **Reset mid-WAIT**: assert `rst`=0 mid-WAIT → outputs 0 at once; after release, `in_ready`=0 for 64 cycles; stray `alu_done` at cycle 10 produces no writeback.
- **Operand hold**: change `in_rs1_data` while in WAIT → `alu_rs1` unchanged; a second `in_valid` during WAIT is not accepted.
